// File: rtl/acc_pkg.sv
// Shared types and constants for the dual-range current accumulator.
package acc_pkg;

    localparam int ADC_W  = 12;
    localparam int ADC_FS = 4095;

    localparam int FLAG_W        = 3;
    localparam int FLAG_SAT      = 2;
    localparam int FLAG_OVF_BOTH = 1;
    localparam int FLAG_MA_USED  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SNAP  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    typedef logic [FLAG_W-1:0] flags_t;

    typedef struct packed {
        logic [ADC_W-1:0] ua;
        logic             ua_ovf;
        logic [ADC_W-1:0] ma;
        logic             ma_ovf;
    } sample_t;

endpackage

// File: rtl/acc_sequencer_if.sv
// Sample strobe, snapshot readout and LED bundle between the front end/SPI side and the sequencer.
interface acc_sequencer_if #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
);
    import acc_pkg::*;

    logic                en;
    logic                sample_vld;
    logic [ADC_W-1:0]    ua;
    logic                ua_ovf;
    logic [ADC_W-1:0]    ma;
    logic                ma_ovf;
    logic                snap_req;
    logic                clr_req;
    logic                snap_ack;
    logic [ACC_W-1:0]    snap_sum;
    logic [CNT_W-1:0]    snap_cnt;
    logic [FLAG_W-1:0]   snap_flags;
    logic                led_1;
    logic                led_2;
    logic                led_3;

    modport master (
        output en, sample_vld, ua, ua_ovf, ma, ma_ovf, snap_req, clr_req,
        input  snap_ack, snap_sum, snap_cnt, snap_flags, led_1, led_2, led_3
    );

    modport slave (
        input  en, sample_vld, ua, ua_ovf, ma, ma_ovf, snap_req, clr_req,
        output snap_ack, snap_sum, snap_cnt, snap_flags, led_1, led_2, led_3
    );

endinterface

// File: rtl/acc_range_select.sv
// Stage 1: picks uA or mA conversion from the overflow flags and scales to uA LSBs.
// Latency: 1 cycle from accepted strobe to s1_vld.
// Backpressure: none; every accepted strobe is registered.
module acc_range_select
    import acc_pkg::*;
#(
    parameter int MA_SHIFT = 10,
    parameter int VAL_W    = ADC_W + MA_SHIFT
) (
    input  logic             acc_clk,
    input  logic             reset,
    input  logic             accept,
    input  sample_t          sample,
    output logic             s1_vld,
    output logic [VAL_W-1:0] s1_value,
    output logic             s1_ma_used,
    output logic             s1_ovf_both
);

    logic [VAL_W-1:0] value_d;
    logic             ma_used_d;
    logic             ovf_both_d;

    always_comb begin
        value_d    = '0;
        ma_used_d  = 1'b0;
        ovf_both_d = 1'b0;
        if (!sample.ua_ovf) begin
            value_d = VAL_W'(sample.ua);
        end else if (!sample.ma_ovf) begin
            value_d   = VAL_W'(sample.ma) << MA_SHIFT;
            ma_used_d = 1'b1;
        end else begin
            // Both ranges clipped: report mA full scale as the best lower bound.
            value_d    = VAL_W'(ADC_FS) << MA_SHIFT;
            ovf_both_d = 1'b1;
        end
    end

    always_ff @(posedge acc_clk or negedge reset) begin
        if (!reset) begin
            s1_vld      <= 1'b0;
            s1_value    <= '0;
            s1_ma_used  <= 1'b0;
            s1_ovf_both <= 1'b0;
        end else begin
            s1_vld      <= accept;
            s1_value    <= accept ? value_d : '0;
            s1_ma_used  <= accept & ma_used_d;
            s1_ovf_both <= accept & ovf_both_d;
        end
    end

endmodule

// File: rtl/acc_sequencer.sv
// Dual-range current accumulator sequencer: windowed accumulation, snapshot freeze, status LEDs.
// Latency: sample in accumulator 2 cycles after strobe; snap_ack 2 cycles after a snapshot trigger.
// Backpressure: none; snap_req is a level acknowledged once. ACC_SATURATE_EN clamps instead of wrapping.
module acc_sequencer
    import acc_pkg::*;
#(
    parameter int ACC_W      = 40,
    parameter int MA_SHIFT   = 10,
    parameter int WINDOW_LEN = 1000,
    parameter int CNT_W      = 16
) (
    input  logic            acc_clk,
    input  logic            reset,
    acc_sequencer_if.slave  bus
);

    localparam int               VAL_W    = ADC_W + MA_SHIFT;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_LEN - 1);
    localparam bit               AUTO_WIN = (WINDOW_LEN != 0);

    state_t             state;
    state_t             state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    flags_t             flags;
    logic [ACC_W-1:0]   snap_sum;
    logic [CNT_W-1:0]   snap_cnt;
    flags_t             snap_flags;
    logic               snap_ack;
    logic               served;

    sample_t            sample;
    logic               s1_vld;
    logic [VAL_W-1:0]   s1_value;
    logic               s1_ma_used;
    logic               s1_ovf_both;

    logic               fresh;
    logic [ACC_W-1:0]   acc_base;
    logic [CNT_W-1:0]   cnt_base;
    flags_t             flags_base;
    logic [ACC_W:0]     sum_ext;
    logic [ACC_W-1:0]   acc_add;
    logic [CNT_W-1:0]   cnt_add;
    flags_t             flags_add;
    logic               win_end;
    logic               snap_cond;

    assign sample = '{ua: bus.ua, ua_ovf: bus.ua_ovf, ma: bus.ma, ma_ovf: bus.ma_ovf};

    acc_range_select #(.MA_SHIFT(MA_SHIFT)) u_range_select (
        .acc_clk     (acc_clk),
        .reset       (reset),
        .accept      (bus.en & bus.sample_vld),
        .sample      (sample),
        .s1_vld      (s1_vld),
        .s1_value    (s1_value),
        .s1_ma_used  (s1_ma_used),
        .s1_ovf_both (s1_ovf_both)
    );

    // SNAP and CLEAR start a fresh window, so an add landing in that cycle opens it.
    assign fresh = (state == SNAP) || (state == CLEAR);

    always_comb begin
        acc_base   = fresh ? '0 : acc;
        cnt_base   = fresh ? '0 : cnt;
        flags_base = fresh ? '0 : flags;
        sum_ext    = {1'b0, acc_base} + {{(ACC_W + 1 - VAL_W){1'b0}}, s1_value};
        acc_add    = acc_base;
        cnt_add    = cnt_base;
        flags_add  = flags_base;
        if (s1_vld) begin
            cnt_add                  = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
            flags_add[FLAG_MA_USED]  = flags_base[FLAG_MA_USED] | s1_ma_used;
            flags_add[FLAG_OVF_BOTH] = flags_base[FLAG_OVF_BOTH] | s1_ovf_both;
            acc_add                  = sum_ext[ACC_W-1:0];
            if (sum_ext[ACC_W]) begin
                flags_add[FLAG_SAT] = 1'b1;
`ifdef ACC_SATURATE_EN
                acc_add = '1;
`else
                acc_add = sum_ext[ACC_W-1:0];
`endif
            end
        end
    end

    // The sample that brings the count to WINDOW_LEN closes the window it belongs to.
    assign win_end   = AUTO_WIN && s1_vld && (cnt_base == WIN_LAST);
    assign snap_cond = (bus.snap_req && !served) || win_end;

    always_ff @(posedge acc_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (snap_cond) begin
            state_nxt = SNAP;
        end else if (bus.clr_req) begin
            state_nxt = CLEAR;
        end else if (bus.en) begin
            state_nxt = RUN;
        end else begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge acc_clk or negedge reset) begin
        if (!reset) begin
            acc        <= '0;
            cnt        <= '0;
            flags      <= '0;
            snap_sum   <= '0;
            snap_cnt   <= '0;
            snap_flags <= '0;
            snap_ack   <= 1'b0;
            served     <= 1'b0;
        end else begin
            acc      <= acc_add;
            cnt      <= cnt_add;
            flags    <= flags_add;
            snap_ack <= 1'b0;
            if (state == SNAP) begin
                snap_sum   <= acc;
                snap_cnt   <= cnt;
                snap_flags <= flags;
                snap_ack   <= 1'b1;
            end
            // Marked on the transition edge so a held request cannot retrigger from SNAP.
            if (!bus.snap_req) begin
                served <= 1'b0;
            end else if (state_nxt == SNAP) begin
                served <= 1'b1;
            end
        end
    end

    assign bus.snap_ack   = snap_ack;
    assign bus.snap_sum   = snap_sum;
    assign bus.snap_cnt   = snap_cnt;
    assign bus.snap_flags = snap_flags;
    assign bus.led_1      = (state == RUN);
    assign bus.led_2      = flags[FLAG_MA_USED];
    assign bus.led_3      = flags[FLAG_OVF_BOTH];

endmodule

// File: tb/tb_acc_sequencer.sv
// Scoreboarded bench for acc_sequencer with ACC_W=23 and WINDOW_LEN=6 to reach wrap and window edges quickly.
module tb_acc_sequencer;
    import acc_pkg::*;

    localparam int ACC_W      = 23;
    localparam int CNT_W      = 16;
    localparam int WINDOW_LEN = 6;
    localparam int MA_SHIFT   = 10;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] cnt;
        logic [2:0]       flags;
    } exp_t;

    logic acc_clk;
    logic reset;
    int   n_vec;
    int   n_err;
    exp_t exp_q[$];

    acc_sequencer_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    acc_sequencer #(
        .ACC_W(ACC_W), .MA_SHIFT(MA_SHIFT), .WINDOW_LEN(WINDOW_LEN), .CNT_W(CNT_W)
    ) dut (
        .acc_clk (acc_clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial begin
        acc_clk = 1'b0;
        forever #5 acc_clk = ~acc_clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge acc_clk);
    endtask

    task automatic strobes(input int n, input logic [11:0] u, input logic uo,
                           input logic [11:0] m, input logic mo);
        for (int i = 0; i < n; i++) begin
            @(negedge acc_clk);
            bus.sample_vld = 1'b1;
            bus.ua = u; bus.ua_ovf = uo; bus.ma = m; bus.ma_ovf = mo;
        end
        @(negedge acc_clk);
        bus.sample_vld = 1'b0;
    endtask

    task automatic push_exp(input logic [ACC_W-1:0] s, input logic [CNT_W-1:0] c, input logic [2:0] f);
        exp_t e;
        e.sum = s; e.cnt = c; e.flags = f;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge acc_clk);
            if (bus.snap_ack === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_timeout: no snap_ack within 20 cycles, expected 1");
        end
    endtask

    task automatic do_snap(input logic [ACC_W-1:0] s, input logic [CNT_W-1:0] c, input logic [2:0] f);
        push_exp(s, c, f);
        @(negedge acc_clk);
        bus.snap_req = 1'b1;
        wait_ack();
        bus.snap_req = 1'b0;
        @(negedge acc_clk);
    endtask

    // Monitor: every snap_ack must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge acc_clk);
            if (bus.snap_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: got snap_ack=1 sum %0d, expected no ack", bus.snap_sum);
                end else begin
                    e = exp_q.pop_front();
                    check("snap_sum", 64'(bus.snap_sum), 64'(e.sum));
                    check("snap_cnt", 64'(bus.snap_cnt), 64'(e.cnt));
                    check("snap_flags", 64'(bus.snap_flags), 64'(e.flags));
                end
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.en = 1'b0; bus.sample_vld = 1'b0; bus.ua = '0; bus.ua_ovf = 1'b0;
        bus.ma = '0; bus.ma_ovf = 1'b0; bus.snap_req = 1'b0; bus.clr_req = 1'b0;
        #3;
        check("reset_sum", 64'(bus.snap_sum), 64'd0);
        check("reset_cnt", 64'(bus.snap_cnt), 64'd0);
        check("reset_flags", 64'(bus.snap_flags), 64'd0);
        check("reset_ack", 64'(bus.snap_ack), 64'd0);
        check("reset_leds", 64'({bus.led_1, bus.led_2, bus.led_3}), 64'd0);
        idle(3);
        reset = 1'b1;
        idle(2);
        check("idle_led1", 64'(bus.led_1), 64'd0);
        bus.en = 1'b1;
        idle(2);
        check("run_led1", 64'(bus.led_1), 64'd1);

        // uA range only
        strobes(5, 12'd100, 1'b0, 12'd0, 1'b0);
        idle(3);
        do_snap(23'd500, 16'd5, 3'b000);

        // mA range
        strobes(1, 12'd0, 1'b1, 12'd3, 1'b0);
        idle(3);
        check("led2_ma_used", 64'(bus.led_2), 64'd1);
        do_snap(23'd3072, 16'd1, 3'b001);
        check("led2_cleared", 64'(bus.led_2), 64'd0);

        // both ranges overflowed
        strobes(2, 12'd0, 1'b1, 12'd7, 1'b1);
        idle(3);
        check("led3_ovf_both", 64'(bus.led_3), 64'd1);
        check("led2_not_ma", 64'(bus.led_2), 64'd0);
        do_snap(23'd8386560, 16'd2, 3'b010);

        // accumulator overflow: 8386560 + 4095 exceeds 2^23-1
        strobes(2, 12'd0, 1'b1, 12'd0, 1'b1);
        strobes(1, 12'd4095, 1'b0, 12'd0, 1'b0);
        idle(3);
`ifdef ACC_SATURATE_EN
        do_snap(23'd8388607, 16'd3, 3'b110);
`else
        do_snap(23'd2047, 16'd3, 3'b110);
`endif

        // automatic window end coinciding with snap_req: one ack only
        push_exp(23'd6, 16'd6, 3'b000);
        for (int i = 0; i < WINDOW_LEN; i++) begin
            @(negedge acc_clk);
            bus.sample_vld = 1'b1;
            bus.ua = 12'd1; bus.ua_ovf = 1'b0; bus.ma = '0; bus.ma_ovf = 1'b0;
        end
        @(negedge acc_clk);
        bus.sample_vld = 1'b0;
        bus.snap_req = 1'b1;
        wait_ack();
        idle(3);
        bus.snap_req = 1'b0;
        idle(1);
        strobes(2, 12'd1, 1'b0, 12'd0, 1'b0);
        idle(3);
        do_snap(23'd2, 16'd2, 3'b000);

        // clear drops the live window but keeps the snapshot
        strobes(3, 12'd7, 1'b0, 12'd0, 1'b0);
        idle(3);
        @(negedge acc_clk);
        bus.clr_req = 1'b1;
        @(negedge acc_clk);
        bus.clr_req = 1'b0;
        idle(2);
        check("clear_keeps_snap", 64'(bus.snap_sum), 64'd2);
        strobes(1, 12'd9, 1'b0, 12'd0, 1'b0);
        idle(3);
        do_snap(23'd9, 16'd1, 3'b000);

        // asynchronous reset mid-window
        strobes(1, 12'd1234, 1'b0, 12'd0, 1'b0);
        idle(3);
        bus.en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("arst_sum", 64'(bus.snap_sum), 64'd0);
        check("arst_cnt", 64'(bus.snap_cnt), 64'd0);
        check("arst_flags", 64'(bus.snap_flags), 64'd0);
        check("arst_leds", 64'({bus.led_1, bus.led_2, bus.led_3}), 64'd0);
        idle(2);
        reset = 1'b1;
        idle(3);
        check("post_rst_idle", 64'(bus.led_1), 64'd0);
        strobes(1, 12'd5, 1'b0, 12'd0, 1'b0);
        idle(3);
        bus.en = 1'b1;
        idle(2);
        check("post_rst_run", 64'(bus.led_1), 64'd1);
        strobes(1, 12'd20, 1'b0, 12'd0, 1'b0);
        idle(3);
        bus.en = 1'b0;
        idle(2);
        check("en_low_idle", 64'(bus.led_1), 64'd0);
        bus.en = 1'b1;
        idle(1);
        strobes(1, 12'd30, 1'b0, 12'd0, 1'b0);
        idle(3);
        do_snap(23'd50, 16'd2, 3'b000);

        idle(5);
        check("pending_snaps", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
